// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] REGION_DMEM = 2'b00;
  localparam logic [1:0] REGION_IO   = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } lsu_state_t;

  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LW:   return word;
      F3_LBU:  return {24'h0, b};
      F3_LHU:  return {16'h0, h};
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] offset,
                                          input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return 4'b0001 << offset;
      F3_SH:   return offset[1] ? 4'b1100 : 4'b0011;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-wide data RAM with per-byte write enables and a registered read port.
module lsu_dmem #(
  parameter int unsigned AW       = 10,
  parameter string       MEM_FILE = "mem_init_zeros.hex"
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-3:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  localparam int unsigned DEPTH = 1 << (AW - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]   <= wdata[7:0];
      if (be[1]) mem[addr][15:8]  <= wdata[15:8];
      if (be[2]) mem[addr][23:16] <= wdata[23:16];
      if (be[3]) mem[addr][31:24] <= wdata[31:24];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Load/store unit: request/response FSM in front of a byte-enabled data RAM
// and a memory-mapped IO register file with synchronised inputs.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW  = 10,
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned N_IN     = 2,
  parameter string       MEM_FILE = "mem_init_zeros.hex"
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wren,
  input  logic [31:0]       i_req_addr,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  input  logic [N_IN*32-1:0]  i_io_in,
  output logic [N_OUT*32-1:0] o_io_out
);
  localparam int unsigned WW = DMEM_AW - 2;

  lsu_state_t state_q, state_d;

  logic [1:0]    region;
  logic [WW-1:0] w_idx;
  logic [1:0]    offset;
  logic          unused_addr_hi;
  logic          f3_legal, misaligned, is_dmem, is_out, is_in, req_err;
  logic          accept, wr_ok, dmem_we;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   dmem_rdata, io_rd;

  logic [WW-1:0] lat_w;
  logic [1:0]    lat_offset;
  logic [2:0]    lat_funct3;
  logic          lat_is_io, lat_err;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0]        io_out_q [N_OUT];
  logic [31:0]        io_in_w  [N_IN];
  logic [N_IN*32-1:0] io_s1, io_s2;

  assign region         = i_req_addr[DMEM_AW+1:DMEM_AW];
  assign w_idx          = i_req_addr[DMEM_AW-1:2];
  assign offset         = i_req_addr[1:0];
  assign unused_addr_hi = ^i_req_addr[31:DMEM_AW+2];

  always_comb begin
    is_dmem = (region == REGION_DMEM);
    is_out  = (region == REGION_IO) && (32'(w_idx) < N_OUT);
    is_in   = (region == REGION_IO) && (32'(w_idx) >= N_OUT) && (32'(w_idx) < N_OUT + N_IN);
    if (i_req_wren) f3_legal = i_req_funct3 inside {F3_SB, F3_SH, F3_SW};
    else            f3_legal = i_req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    misaligned = ((i_req_funct3[1:0] == 2'b01) && offset[0]) ||
                 ((i_req_funct3[1:0] == 2'b10) && (offset != 2'b00));
    req_err = !f3_legal || misaligned || !(is_dmem || is_out || is_in) || (i_req_wren && is_in);
    be = store_be(offset, i_req_funct3);
    case (i_req_funct3[1:0])
      2'b00:   wdata_rep = {4{i_req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{i_req_wdata[15:0]}};
      default: wdata_rep = i_req_wdata;
    endcase
  end

  // A store presented on the reset edge must not land.
  assign accept  = (state_q == IDLE) && i_req_valid;
  assign wr_ok   = accept && i_req_wren && !req_err && !i_rst;
  assign dmem_we = wr_ok && is_dmem;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_req_valid) state_d = i_req_wren ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_d = RESP;
      RESP:      if (i_rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  lsu_dmem #(
    .AW       (DMEM_AW),
    .MEM_FILE (MEM_FILE)
  ) u_dmem (
    .clk   (i_clk),
    .we    (dmem_we),
    .be    (be),
    .addr  (w_idx),
    .wdata (wdata_rep),
    .rdata (dmem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      io_s1 <= '0;
      io_s2 <= '0;
    end else begin
      io_s1 <= i_io_in;
      io_s2 <= io_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (i_rst) begin
        io_out_q[k] <= '0;
      end else if (wr_ok && is_out && (32'(w_idx) == k)) begin
        if (be[0]) io_out_q[k][7:0]   <= wdata_rep[7:0];
        if (be[1]) io_out_q[k][15:8]  <= wdata_rep[15:8];
        if (be[2]) io_out_q[k][23:16] <= wdata_rep[23:16];
        if (be[3]) io_out_q[k][31:24] <= wdata_rep[31:24];
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign o_io_out[32*g +: 32] = io_out_q[g];
  end
  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign io_in_w[g] = io_s2[32*g +: 32];
  end

  always_comb begin
    io_rd = '0;
    for (int unsigned k = 0; k < N_OUT; k++)
      if (32'(lat_w) == k) io_rd = io_out_q[k];
    for (int unsigned k = 0; k < N_IN; k++)
      if (32'(lat_w) == N_OUT + k) io_rd = io_in_w[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      lat_w       <= '0;
      lat_offset  <= '0;
      lat_funct3  <= '0;
      lat_is_io   <= 1'b0;
      lat_err     <= 1'b0;
    end else begin
      if (accept) begin
        lat_w      <= w_idx;
        lat_offset <= offset;
        lat_funct3 <= i_req_funct3;
        lat_is_io  <= (region == REGION_IO);
        lat_err    <= req_err;
        if (i_req_wren) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= req_err;
        end
      end
      if (state_q == LOAD_WAIT) begin
        rsp_rdata_q <= lat_err ? '0
                     : load_format(lat_is_io ? io_rd : dmem_rdata, lat_offset, lat_funct3);
        rsp_err_q   <= lat_err;
      end
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
